// File: rtl/controlador_es_pkg.sv
// Shared types and seven-segment helpers for the IN/OUT controller.
package io_pkg;

   typedef enum logic [2:0] {
      OCIOSO,
      ESPERA_PRESS,
      CONVERTE,
      ESPERA_SOLTA,
      ESPERA_TICK
   } estado_t;

   // Active-low segment patterns, bit 0 = a ... bit 6 = g
   localparam logic [6:0] SEG_MENOS   = 7'h3F;
   localparam logic [6:0] SEG_E       = 7'h06;
   localparam logic [6:0] SEG_APAGADO = 7'h7F;

   function automatic logic [6:0] bcd_para_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return SEG_APAGADO;
      endcase
   endfunction

   function automatic logic [63:0] pot10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/controlador_es_if.sv
// Handshake and board-pin bundle between control unit, board and controller.
interface controlador_es_if #(
   parameter int DATA_WIDTH = 32,
   parameter int SW_WIDTH   = 8,
   parameter int N_DIGITS   = 4
);
   logic                    req_in;
   logic                    req_out;
   logic                    tick_cpu;
   logic [DATA_WIDTH-1:0]   dado_out;
   logic [SW_WIDTH-1:0]     switches;
   logic                    botao;
   logic                    congela;
   logic [DATA_WIDTH-1:0]   dado_in;
   logic                    in_valido;
   logic                    ocupado;
   logic [7*N_DIGITS-1:0]   segmentos;

   modport master (
      output req_in, req_out, tick_cpu, dado_out, switches, botao,
      input  congela, dado_in, in_valido, ocupado, segmentos
   );

   modport slave (
      input  req_in, req_out, tick_cpu, dado_out, switches, botao,
      output congela, dado_in, in_valido, ocupado, segmentos
   );
endinterface

// File: rtl/controlador_es_debounce.sv
// Confirm-button synchroniser and debouncer; button is active-low, level is 1 when pressed.
module debounce_botao #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock_fpga,
   input  logic reset,
   input  logic botao,
   output logic level,
   output logic press,
   output logic solta
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CARGA = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1, s2;
   logic          amostra;
   logic [CW-1:0] cont;

   assign amostra = ~s2;

   // Down-counter reloads on every sample that agrees with the accepted level
   always_ff @(posedge clock_fpga or posedge reset) begin
      if (reset) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         cont  <= CARGA;
         level <= 1'b0;
         press <= 1'b0;
         solta <= 1'b0;
      end else begin
         s1    <= botao;
         s2    <= s1;
         press <= 1'b0;
         solta <= 1'b0;
         if (amostra == level) begin
            cont <= CARGA;
         end else if (cont == '0) begin
            level <= amostra;
            press <= amostra;
            solta <= ~amostra;
            cont  <= CARGA;
         end else begin
            cont <= cont - 1'b1;
         end
      end
   end
endmodule

// File: rtl/controlador_es.sv
// IN/OUT controller: freezes the CPU clock, captures switches on a debounced press and
// converts the value to N seven-segment digits by sequential double-dabble.
//   state        | meaning
//   OCIOSO       | idle, waiting for req_in / req_out
//   ESPERA_PRESS | clock frozen, waiting for a debounced press
//   CONVERTE     | DATA_WIDTH double-dabble shift cycles
//   ESPERA_SOLTA | waiting for the button to be released
//   ESPERA_TICK  | waiting for the CPU clock edge that ends the instruction
module controlador_es
   import io_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int SW_WIDTH        = 8,
   parameter int N_DIGITS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MODO_SINAL      = 1
) (
   input logic              clock_fpga,
   input logic              reset,
   controlador_es_if.slave  bus
);
   localparam int BW  = 4 * N_DIGITS;
   localparam int CCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [63:0] LIM_POS = pot10(N_DIGITS) - 64'd1;
   localparam logic [63:0] LIM_NEG = pot10(N_DIGITS - 1) - 64'd1;

   estado_t estado, estado_prox;
   logic                  eh_in;
   logic                  press, solta, nivel;
   logic                  carrega_in, carrega_out, fim_conv, valida;
   logic [SW_WIDTH-1:0]   sw_amostra;
   logic [DATA_WIDTH-1:0] valor_carga, mag_carga, fonte, dado_in_r;
   logic                  neg_carga, exc_carga, negativo, excede, in_valido_r;
   logic [BW-1:0]         bcd, bcd_aj, bcd_prox;
   logic [CCW-1:0]        ciclos;
   logic [7*N_DIGITS-1:0] seg_prox, seg_r;

   debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clock_fpga (clock_fpga),
      .reset      (reset),
      .botao      (bus.botao),
      .level      (nivel),
      .press      (press),
      .solta      (solta)
   );

   always_ff @(posedge clock_fpga or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= estado_prox;
   end

   always_comb begin
      estado_prox = estado;
      carrega_in  = 1'b0;
      carrega_out = 1'b0;
      fim_conv    = 1'b0;
      valida      = 1'b0;
      case (estado)
         OCIOSO: begin
            if (bus.req_in) begin
               estado_prox = ESPERA_PRESS;
            end else if (bus.req_out) begin
               carrega_out = 1'b1;
               estado_prox = CONVERTE;
            end
         end
         ESPERA_PRESS: begin
            if (press) begin
               carrega_in  = eh_in;
               estado_prox = eh_in ? CONVERTE : ESPERA_SOLTA;
            end
         end
         CONVERTE: begin
            if (ciclos == '0) begin
               fim_conv    = 1'b1;
               estado_prox = eh_in ? ESPERA_SOLTA : ESPERA_PRESS;
            end
         end
         ESPERA_SOLTA: begin
            // Level check also covers a release that happened while converting
            if (solta || !nivel) begin
               valida      = eh_in;
               estado_prox = ESPERA_TICK;
            end
         end
         ESPERA_TICK: begin
            if (bus.tick_cpu) estado_prox = OCIOSO;
         end
         default: estado_prox = OCIOSO;
      endcase
   end

   assign sw_amostra  = bus.switches;
   assign valor_carga = carrega_in ? DATA_WIDTH'(sw_amostra) : bus.dado_out;
   assign neg_carga   = (MODO_SINAL != 0) && valor_carga[DATA_WIDTH-1];
   assign mag_carga   = neg_carga ? (~valor_carga + DATA_WIDTH'(1)) : valor_carga;
   assign exc_carga   = neg_carga ? (64'(mag_carga) > LIM_NEG) : (64'(mag_carga) > LIM_POS);

   always_comb begin
      bcd_aj = bcd;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) bcd_aj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      bcd_prox = {bcd_aj[BW-2:0], fonte[DATA_WIDTH-1]};
   end

   always_comb begin
      seg_prox = '1;
      for (int k = 0; k < N_DIGITS; k++) seg_prox[7*k +: 7] = bcd_para_seg(bcd_prox[4*k +: 4]);
      if (excede) begin
         seg_prox = '1;
         seg_prox[7*(N_DIGITS-1) +: 7] = SEG_E;
      end else if (negativo) begin
         seg_prox[7*(N_DIGITS-1) +: 7] = SEG_MENOS;
      end
   end

   always_ff @(posedge clock_fpga or posedge reset) begin
      if (reset) begin
         eh_in       <= 1'b0;
         dado_in_r   <= '0;
         in_valido_r <= 1'b0;
         fonte       <= '0;
         bcd         <= '0;
         negativo    <= 1'b0;
         excede      <= 1'b0;
         ciclos      <= '0;
         seg_r       <= '1;
      end else begin
         in_valido_r <= valida;
         if (estado == OCIOSO) eh_in <= bus.req_in;
         if (carrega_in) dado_in_r <= DATA_WIDTH'(sw_amostra);
         if (carrega_in || carrega_out) begin
            fonte    <= mag_carga;
            negativo <= neg_carga;
            excede   <= exc_carga;
            bcd      <= '0;
            ciclos   <= CCW'(DATA_WIDTH - 1);
         end else if (estado == CONVERTE) begin
            fonte  <= fonte << 1;
            bcd    <= bcd_prox;
            ciclos <= ciclos - 1'b1;
            if (fim_conv) seg_r <= seg_prox;
         end
      end
   end

   assign bus.congela   = (estado == ESPERA_PRESS) || (estado == CONVERTE) || (estado == ESPERA_SOLTA);
   assign bus.ocupado   = (estado != OCIOSO);
   assign bus.dado_in   = dado_in_r;
   assign bus.in_valido = in_valido_r;
   assign bus.segmentos = seg_r;
endmodule

// File: tb/tb_controlador_es.sv
// Bench for controlador_es: one unsigned and one signed instance share the same stimulus.
module tb_controlador_es;
   localparam int DW = 32;
   localparam int SW = 8;
   localparam int ND = 4;
   localparam int DC = 4;

   localparam logic [6:0] GLIFO [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   localparam logic [6:0] G_MENOS = 7'h40;
   localparam logic [6:0] G_E     = 7'h79;
   localparam logic [7*ND-1:0] APAGADO = '1;

   logic clock_fpga = 1'b0;
   logic reset = 1'b1;
   logic req_in = 1'b0, req_out = 1'b0, tick_cpu = 1'b0, botao = 1'b1;
   logic [DW-1:0] dado_out = '0;
   logic [SW-1:0] switches = '0;

   int checks = 0;
   int errors = 0;
   int pulsos_u = 0;
   int pulsos_s = 0;
   logic [7*ND-1:0] exp_u, exp_s;
   logic [DW-1:0]   exp_dado;

   always #5 clock_fpga = ~clock_fpga;

   controlador_es_if #(.DATA_WIDTH(DW), .SW_WIDTH(SW), .N_DIGITS(ND)) ifu ();
   controlador_es_if #(.DATA_WIDTH(DW), .SW_WIDTH(SW), .N_DIGITS(ND)) ifs ();

   assign ifu.req_in = req_in;     assign ifs.req_in = req_in;
   assign ifu.req_out = req_out;   assign ifs.req_out = req_out;
   assign ifu.tick_cpu = tick_cpu; assign ifs.tick_cpu = tick_cpu;
   assign ifu.dado_out = dado_out; assign ifs.dado_out = dado_out;
   assign ifu.switches = switches; assign ifs.switches = switches;
   assign ifu.botao = botao;       assign ifs.botao = botao;

   controlador_es #(.DATA_WIDTH(DW), .SW_WIDTH(SW), .N_DIGITS(ND),
                    .DEBOUNCE_CYCLES(DC), .MODO_SINAL(0)) dut_u (
      .clock_fpga (clock_fpga), .reset (reset), .bus (ifu));

   controlador_es #(.DATA_WIDTH(DW), .SW_WIDTH(SW), .N_DIGITS(ND),
                    .DEBOUNCE_CYCLES(DC), .MODO_SINAL(1)) dut_s (
      .clock_fpga (clock_fpga), .reset (reset), .bus (ifs));

   always @(negedge clock_fpga) begin
      if (ifu.in_valido === 1'b1) pulsos_u++;
      if (ifs.in_valido === 1'b1) pulsos_s++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, observed timeout, expected completion");
      $fatal(1);
   end

   // Expected display from the decimal value of the word
   function automatic logic [7*ND-1:0] modelo(input logic [DW-1:0] v, input bit sinal);
      logic [7*ND-1:0] r;
      longint mag, lim, p;
      bit neg;
      neg = sinal && v[DW-1];
      mag = neg ? ((longint'(1) << DW) - longint'(v)) : longint'(v);
      lim = 1;
      for (int i = 0; i < (neg ? ND - 1 : ND); i++) lim = lim * 10;
      lim = lim - 1;
      r = '1;
      if (mag > lim) begin
         r[7*(ND-1) +: 7] = ~G_E;
      end else begin
         p = 1;
         for (int k = 0; k < ND; k++) begin
            r[7*k +: 7] = ~GLIFO[int'((mag / p) % 10)];
            p = p * 10;
         end
         if (neg) r[7*(ND-1) +: 7] = ~G_MENOS;
      end
      return r;
   endfunction

   task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
      checks++;
      assert (obs === esp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, esp);
      end
   endtask

   task automatic passo();
      @(posedge clock_fpga);
      #1;
   endtask

   task automatic verifica_repouso(input string tag);
      verifica({tag, "/congela_u"}, 64'(ifu.congela), 64'd0);
      verifica({tag, "/congela_s"}, 64'(ifs.congela), 64'd0);
      verifica({tag, "/ocupado_u"}, 64'(ifu.ocupado), 64'd0);
      verifica({tag, "/ocupado_s"}, 64'(ifs.ocupado), 64'd0);
      verifica({tag, "/in_valido_u"}, 64'(ifu.in_valido), 64'd0);
      verifica({tag, "/dado_in_u"}, 64'(ifu.dado_in), 64'd0);
      verifica({tag, "/dado_in_s"}, 64'(ifs.dado_in), 64'd0);
      verifica({tag, "/seg_u"}, 64'(ifu.segmentos), 64'(APAGADO));
      verifica({tag, "/seg_s"}, 64'(ifs.segmentos), 64'(APAGADO));
   endtask

   task automatic transacao_out(input logic [DW-1:0] v);
      logic [7*ND-1:0] nu, ns;
      nu = modelo(v, 1'b0);
      ns = modelo(v, 1'b1);
      dado_out = v;
      req_out = 1'b1;
      passo();
      req_out = 1'b0;
      verifica("out/congela_inicio_u", 64'(ifu.congela), 64'd1);
      verifica("out/congela_inicio_s", 64'(ifs.congela), 64'd1);
      repeat (DW - 1) passo();
      verifica("out/seg_antes_fim_u", 64'(ifu.segmentos), 64'(exp_u));
      verifica("out/seg_antes_fim_s", 64'(ifs.segmentos), 64'(exp_s));
      passo();
      verifica("out/seg_u", 64'(ifu.segmentos), 64'(nu));
      verifica("out/seg_s", 64'(ifs.segmentos), 64'(ns));
      exp_u = nu;
      exp_s = ns;
      botao = 1'b0;
      repeat (DC + 4) passo();
      verifica("out/congela_apos_press", 64'(ifu.congela), 64'd1);
      botao = 1'b1;
      repeat (DC + 4) passo();
      verifica("out/congela_apos_solta_u", 64'(ifu.congela), 64'd0);
      verifica("out/congela_apos_solta_s", 64'(ifs.congela), 64'd0);
      verifica("out/ocupado_antes_tick", 64'(ifu.ocupado), 64'd1);
      tick_cpu = 1'b1;
      passo();
      tick_cpu = 1'b0;
      verifica("out/ocupado_fim_u", 64'(ifu.ocupado), 64'd0);
      verifica("out/ocupado_fim_s", 64'(ifs.ocupado), 64'd0);
   endtask

   task automatic transacao_in(input logic [SW-1:0] sw, input bit com_out, input bit com_glitch);
      int p0u, p0s;
      switches = sw;
      dado_out = 32'd7777;
      req_in = 1'b1;
      req_out = com_out;
      passo();
      verifica("in/congela_inicio_u", 64'(ifu.congela), 64'd1);
      verifica("in/congela_inicio_s", 64'(ifs.congela), 64'd1);
      if (com_glitch) begin
         botao = 1'b0;
         repeat (3) passo();
         botao = 1'b1;
         repeat (DC + 6) passo();
         verifica("glitch/congela", 64'(ifu.congela), 64'd1);
         verifica("glitch/dado_in_u", 64'(ifu.dado_in), 64'(exp_dado));
         verifica("glitch/dado_in_s", 64'(ifs.dado_in), 64'(exp_dado));
      end
      botao = 1'b0;
      repeat (DC + 4 + DW) passo();
      exp_dado = DW'(sw);
      exp_u = modelo(exp_dado, 1'b0);
      exp_s = modelo(exp_dado, 1'b1);
      verifica("in/dado_in_u", 64'(ifu.dado_in), 64'(exp_dado));
      verifica("in/dado_in_s", 64'(ifs.dado_in), 64'(exp_dado));
      verifica("in/seg_u", 64'(ifu.segmentos), 64'(exp_u));
      verifica("in/seg_s", 64'(ifs.segmentos), 64'(exp_s));
      verifica("in/congela_ate_solta", 64'(ifu.congela), 64'd1);
      p0u = pulsos_u;
      p0s = pulsos_s;
      botao = 1'b1;
      repeat (DC + 4 + 5) passo();
      verifica("in/pulsos_in_valido_u", 64'(pulsos_u - p0u), 64'd1);
      verifica("in/pulsos_in_valido_s", 64'(pulsos_s - p0s), 64'd1);
      verifica("in/congela_apos_solta", 64'(ifu.congela), 64'd0);
      verifica("in/sem_redisparo_u", 64'(ifu.ocupado), 64'd1);
      verifica("in/sem_redisparo_s", 64'(ifs.ocupado), 64'd1);
      req_in = 1'b0;
      req_out = 1'b0;
      tick_cpu = 1'b1;
      passo();
      tick_cpu = 1'b0;
      verifica("in/ocupado_fim_u", 64'(ifu.ocupado), 64'd0);
      verifica("in/ocupado_fim_s", 64'(ifs.ocupado), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] v;
      exp_u = APAGADO;
      exp_s = APAGADO;
      exp_dado = '0;

      repeat (3) passo();
      verifica_repouso("reset");
      reset = 1'b0;
      passo();
      verifica_repouso("pos_reset");

      transacao_out(32'd1234);
      transacao_out(32'hFFFF_FFD6);
      transacao_out(32'd10000);
      transacao_in(8'hFF, 1'b0, 1'b1);

      transacao_out(32'd9999);
      transacao_out(32'hFFFF_FC19);
      transacao_out(32'hFFFF_FC18);
      transacao_out(32'h8000_0000);
      transacao_out(32'd0);

      for (int i = 0; i < 6; i++) begin
         case (i % 3)
            0:       v = $urandom_range(0, 9999);
            1:       v = 32'd0 - $urandom_range(1, 999);
            default: v = $urandom;
         endcase
         transacao_out(v);
         transacao_in(SW'($urandom_range(0, 255)), 1'b1, 1'b0);
      end

      dado_out = 32'd5678;
      req_out = 1'b1;
      passo();
      req_out = 1'b0;
      repeat (10) passo();
      reset = 1'b1;
      #1;
      verifica_repouso("reset_meio");
      passo();
      reset = 1'b0;
      exp_u = APAGADO;
      exp_s = APAGADO;
      exp_dado = '0;
      passo();
      transacao_out(32'd5678);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
